fcp_master_phy: RTL

FCP_MASTER_PHY -- requirements
Module: fcp_master_phy

---
 rtl/fcp_master_phy_pkg.sv | 30 +++
 rtl/fcp_ui_timer.sv | 54 +++++
 rtl/fcp_master_phy.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/fcp_master_phy_pkg.sv
// Shared constants, state encoding and helpers for the FCP master line PHY.
package fcp_master_phy_pkg;

    // Default timing, in unit intervals unless noted; also used by the slave side.
    localparam int unsigned FCP_UI_CYCLES       = 4;   // clk cycles per UI
    localparam int unsigned FCP_PING_UI         = 16;
    localparam int unsigned FCP_RESET_UI        = 100;
    localparam int unsigned FCP_RESP_HIGH_UI    = 8;
    localparam int unsigned FCP_RESP_TIMEOUT_UI = 64;

    // Width of the UI counter and of the slave-ping high-time counter.
    localparam int unsigned UI_CNT_W = 16;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StRst      = 3'd1,
        StPingS    = 3'd2,
        StSync     = 3'd3,
        StBit      = 3'd4,
        StPingE    = 3'd5,
        StWaitResp = 3'd6,
        StDone     = 3'd7
    } state_t;

    // Parity bit that makes the ones-count of byte plus parity odd.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~(^b);
    endfunction

endpackage

// File: rtl/fcp_ui_timer.sv
// Cycle-within-UI counter with UI tick, first-half flag and a UI counter.
module fcp_ui_timer
    import fcp_master_phy_pkg::*;
#(
    parameter int unsigned UI_CYCLES = FCP_UI_CYCLES,
    parameter int unsigned CYC_W     = $clog2(UI_CYCLES)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                clr_i,
    input  logic                load_i,
    input  logic [CYC_W-1:0]    load_val_i,
    output logic                ui_tick_o,
    output logic                first_half_o,
    output logic [UI_CNT_W-1:0] ui_cnt_o
);

    logic [CYC_W-1:0]    cyc_q, cyc_d;
    logic [UI_CNT_W-1:0] ui_q, ui_d;

    assign ui_tick_o    = (cyc_q == CYC_W'(UI_CYCLES - 1));
    assign first_half_o = (cyc_q < CYC_W'(UI_CYCLES / 2));
    assign ui_cnt_o     = ui_q;

    // Next count: clear wins over load; otherwise free-run and wrap each UI.
    always_comb begin
        cyc_d = cyc_q;
        ui_d  = ui_q;
        if (clr_i) begin
            cyc_d = '0;
            ui_d  = '0;
        end else if (load_i) begin
            cyc_d = load_val_i;
            ui_d  = '0;
        end else if (ui_tick_o) begin
            cyc_d = '0;
            ui_d  = ui_q + UI_CNT_W'(1);
        end else begin
            cyc_d = cyc_q + CYC_W'(1);
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cyc_q <= '0;
            ui_q  <= '0;
        end else begin
            cyc_q <= cyc_d;
            ui_q  <= ui_d;
        end
    end

endmodule

// File: rtl/fcp_master_phy.sv
// FCP master line PHY: reset pulse or ping/sync/Manchester frame, then slave-ping wait.
// The FSM runs one cycle ahead of the registered line outputs; the accept cycle
// counts as position 0 of the first segment, so the timer is loaded at 1.
module fcp_master_phy
    import fcp_master_phy_pkg::*;
#(
    parameter int unsigned UI_CYCLES       = FCP_UI_CYCLES,
    parameter int unsigned PING_UI         = FCP_PING_UI,
    parameter int unsigned RESET_UI        = FCP_RESET_UI,
    parameter int unsigned RESP_HIGH_UI    = FCP_RESP_HIGH_UI,
    parameter int unsigned RESP_TIMEOUT_UI = FCP_RESP_TIMEOUT_UI
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        tx_start,
    input  logic        tx_reset_req,
    input  logic [1:0]  tx_len,
    input  logic [23:0] tx_data,
    output logic        busy,
    output logic        done,
    output logic        ack,
    output logic        timeout_err,
    output logic        out_en,
    output logic        data_out,
    input  logic        data
);

    localparam int unsigned CYC_W    = $clog2(UI_CYCLES);
    localparam int unsigned HIGH_CYC = RESP_HIGH_UI * UI_CYCLES;

    state_t              state_q, state_d;
    logic [1:0]          nbytes_q, nbytes_d;
    logic [1:0]          byte_q, byte_d;
    logic [23:0]         payload_q, payload_d;
    logic [UI_CNT_W-1:0] hi_cnt_q, hi_cnt_d;
    logic [1:0]          sync_q;
    logic                res_ack_q, res_ack_d, res_to_q, res_to_d;
    logic                busy_q, busy_d, done_q, done_d, ack_q, ack_d, to_q, to_d;
    logic                out_en_q, out_en_d, line_q, line_d;
    logic                tmr_clr, tmr_load, ui_tick, first_half;
    logic [UI_CNT_W-1:0] ui_cnt;
    logic [7:0]          cur_byte;
    logic                cur_bit;

    fcp_ui_timer #(
        .UI_CYCLES (UI_CYCLES),
        .CYC_W     (CYC_W)
    ) u_timer (
        .clk          (clk),
        .rstn         (rstn),
        .clr_i        (tmr_clr),
        .load_i       (tmr_load),
        .load_val_i   (CYC_W'(1)),
        .ui_tick_o    (ui_tick),
        .first_half_o (first_half),
        .ui_cnt_o     (ui_cnt)
    );

    // Current byte and bit; bit index 8 is the parity bit.
    always_comb begin
        case (byte_q)
            2'd0:    cur_byte = payload_q[23:16];
            2'd1:    cur_byte = payload_q[15:8];
            default: cur_byte = payload_q[7:0];
        endcase
        cur_bit = (ui_cnt < UI_CNT_W'(8)) ? cur_byte[3'd7 - ui_cnt[2:0]] : odd_parity(cur_byte);
    end

    // Next-state, counters and next values of the registered outputs.
    always_comb begin
        state_d   = state_q;
        nbytes_d  = nbytes_q;
        byte_d    = byte_q;
        payload_d = payload_q;
        hi_cnt_d  = '0;
        res_ack_d = res_ack_q;
        res_to_d  = res_to_q;
        tmr_clr   = 1'b0;
        tmr_load  = 1'b0;
        out_en_d  = 1'b0;
        line_d    = 1'b0;
        busy_d    = done_q ? 1'b0 : busy_q;
        done_d    = 1'b0;
        ack_d     = ack_q;
        to_d      = to_q;
        unique case (state_q)
            StIdle: begin
                if (tx_start && !busy_q) begin
                    state_d   = tx_reset_req ? StRst : StPingS;
                    nbytes_d  = (tx_len == 2'd0) ? 2'd1 : tx_len;
                    byte_d    = 2'd0;
                    payload_d = tx_data;
                    res_ack_d = 1'b0;
                    res_to_d  = 1'b0;
                    tmr_load  = 1'b1;
                    out_en_d  = 1'b1;
                    line_d    = 1'b1;
                    busy_d    = 1'b1;
                    ack_d     = 1'b0;
                    to_d      = 1'b0;
                end
            end
            StRst: begin
                out_en_d = 1'b1;
                line_d   = 1'b1;
                if (ui_tick && ui_cnt == UI_CNT_W'(RESET_UI - 1)) begin
                    state_d = StDone;
                    tmr_clr = 1'b1;
                end
            end
            StPingS: begin
                out_en_d = 1'b1;
                line_d   = 1'b1;
                if (ui_tick && ui_cnt == UI_CNT_W'(PING_UI - 1)) begin
                    state_d = StSync;
                    tmr_clr = 1'b1;
                end
            end
            StSync: begin
                out_en_d = 1'b1;
                line_d   = (ui_cnt != '0);
                if (ui_tick && ui_cnt == UI_CNT_W'(1)) begin
                    state_d = (byte_q == nbytes_q) ? StPingE : StBit;
                    tmr_clr = 1'b1;
                end
            end
            StBit: begin
                out_en_d = 1'b1;
                line_d   = first_half ? cur_bit : ~cur_bit;
                if (ui_tick && ui_cnt == UI_CNT_W'(8)) begin
                    byte_d  = byte_q + 2'd1;
                    state_d = StSync;
                    tmr_clr = 1'b1;
                end
            end
            StPingE: begin
                out_en_d = 1'b1;
                line_d   = 1'b1;
                if (ui_tick && ui_cnt == UI_CNT_W'(PING_UI - 1)) begin
                    state_d = StWaitResp;
                    tmr_clr = 1'b1;
                end
            end
            StWaitResp: begin
                hi_cnt_d = sync_q[1] ? hi_cnt_q + UI_CNT_W'(1) : '0;
                // A qualifying ping takes priority over a coincident timeout.
                if (sync_q[1] && hi_cnt_q == UI_CNT_W'(HIGH_CYC - 1)) begin
                    res_ack_d = 1'b1;
                    state_d   = StDone;
                    tmr_clr   = 1'b1;
                end else if (ui_tick && ui_cnt == UI_CNT_W'(RESP_TIMEOUT_UI - 1)) begin
                    res_to_d = 1'b1;
                    state_d  = StDone;
                    tmr_clr  = 1'b1;
                end
            end
            StDone: begin
                done_d  = 1'b1;
                ack_d   = res_ack_q;
                to_d    = res_to_q;
                state_d = StIdle;
                tmr_clr = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    // State, frame context and line-sense synchronizer.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StIdle;
            nbytes_q  <= 2'd0;
            byte_q    <= 2'd0;
            payload_q <= '0;
            hi_cnt_q  <= '0;
            sync_q    <= 2'b00;
            res_ack_q <= 1'b0;
            res_to_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            nbytes_q  <= nbytes_d;
            byte_q    <= byte_d;
            payload_q <= payload_d;
            hi_cnt_q  <= hi_cnt_d;
            sync_q    <= {sync_q[0], data};
            res_ack_q <= res_ack_d;
            res_to_q  <= res_to_d;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ack_q    <= 1'b0;
            to_q     <= 1'b0;
            out_en_q <= 1'b0;
            line_q   <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            done_q   <= done_d;
            ack_q    <= ack_d;
            to_q     <= to_d;
            out_en_q <= out_en_d;
            line_q   <= line_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign ack         = ack_q;
    assign timeout_err = to_q;
    assign out_en      = out_en_q;
    assign data_out    = line_q;

endmodule
